// File: rtl/alu_op_sequencer_if.sv
// Operand/command bus between a request source, the sequencer and the ALU.
// master = sequencer side, slave = the environment (request source, ALU, response sink).
`timescale 1ns/1ps
interface alu_op_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int CMD_W = 4,
    parameter int RES_W = 16
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_opa;
    logic [WIDTH-1:0] req_opb;
    logic             req_cin;
    logic [CMD_W-1:0] req_cmd;
    logic             req_mode;
    logic [1:0]       req_ivld;

    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             cin;
    logic [CMD_W-1:0] cmd;
    logic             mode;
    logic [1:0]       inp_valid;
    logic             ce;

    logic [RES_W-1:0] res;
    logic             cout;
    logic             oflow;
    logic             g;
    logic             e;
    logic             l;
    logic             err;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [RES_W-1:0] rsp_res;
    logic [5:0]       rsp_flags;
    logic             busy;

    modport master (
        input  req_valid, req_opa, req_opb, req_cin, req_cmd, req_mode, req_ivld,
        input  res, cout, oflow, g, e, l, err, rsp_ready,
        output req_ready, opa, opb, cin, cmd, mode, inp_valid, ce,
        output rsp_valid, rsp_res, rsp_flags, busy
    );

    modport slave (
        output req_valid, req_opa, req_opb, req_cin, req_cmd, req_mode, req_ivld,
        output res, cout, oflow, g, e, l, err, rsp_ready,
        input  req_ready, opa, opb, cin, cmd, mode, inp_valid, ce,
        input  rsp_valid, rsp_res, rsp_flags, busy
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Drives one ALU operation per request handshake, waits the command-dependent
// latency, and returns the captured result and flags on a response handshake.
`timescale 1ns/1ps
module alu_op_sequencer #(
    parameter int WIDTH    = 8,
    parameter int CMD_W    = 4,
    parameter int RES_W    = 16,
    parameter int RES_LAT  = 1,
    parameter int MUL_LAT  = 2,
    parameter int MUL_CMD0 = 9,
    parameter int MUL_CMD1 = 10
) (
    input logic              i_clk,
    input logic              i_rst_n,
    alu_op_sequencer_if.master bus
);
    localparam int LAT_MAX = (RES_LAT > MUL_LAT) ? RES_LAT : MUL_LAT;
    localparam int CNT_W   = $clog2(LAT_MAX + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t           r_state,     w_state;
    logic [CNT_W-1:0] r_cnt,       w_cnt;
    logic             r_req_ready, w_req_ready;
    logic [WIDTH-1:0] r_opa,       w_opa;
    logic [WIDTH-1:0] r_opb,       w_opb;
    logic             r_cin,       w_cin;
    logic [CMD_W-1:0] r_cmd,       w_cmd;
    logic             r_mode,      w_mode;
    logic [1:0]       r_inp_valid, w_inp_valid;
    logic             r_ce,        w_ce;
    logic             r_rsp_valid, w_rsp_valid;
    logic [RES_W-1:0] r_rsp_res,   w_rsp_res;
    logic [5:0]       r_rsp_flags, w_rsp_flags;
    logic             w_is_mul;

    assign w_is_mul = bus.req_mode &&
                      ((bus.req_cmd == CMD_W'(MUL_CMD0)) || (bus.req_cmd == CMD_W'(MUL_CMD1)));

    always_comb begin
        // NOTE: every next value starts as its current register, so no branch can infer a latch.
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_opa       = r_opa;
        w_opb       = r_opb;
        w_cin       = r_cin;
        w_cmd       = r_cmd;
        w_mode      = r_mode;
        w_inp_valid = r_inp_valid;
        w_ce        = r_ce;
        w_rsp_valid = r_rsp_valid;
        w_rsp_res   = r_rsp_res;
        w_rsp_flags = r_rsp_flags;

        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid && r_req_ready) begin
                    w_opa       = bus.req_opa;
                    w_opb       = bus.req_opb;
                    w_cin       = bus.req_cin;
                    w_cmd       = bus.req_cmd;
                    w_mode      = bus.req_mode;
                    w_inp_valid = bus.req_ivld;
                    w_ce        = 1'b1;
                    w_cnt       = w_is_mul ? CNT_W'(MUL_LAT) : CNT_W'(RES_LAT);
                    w_state     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // cnt==1 marks the edge at which the ALU result for this op is valid.
                if (r_cnt == CNT_W'(1)) begin
                    w_rsp_res   = bus.res;
                    w_rsp_flags = {bus.cout, bus.oflow, bus.g, bus.e, bus.l, bus.err};
                    w_rsp_valid = 1'b1;
                    w_ce        = 1'b0;
                    w_inp_valid = 2'b00;
                    w_state     = ST_RESP;
                end else begin
                    w_cnt = r_cnt - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    w_rsp_valid = 1'b0;
                    w_state     = ST_IDLE;
                end
            end
            default: w_state = ST_IDLE;
        endcase

        // Registered ready: rises the cycle after the response handshake, never combinationally.
        w_req_ready = (w_state == ST_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_req_ready <= 1'b0;
            r_opa       <= '0;
            r_opb       <= '0;
            r_cin       <= 1'b0;
            r_cmd       <= '0;
            r_mode      <= 1'b0;
            r_inp_valid <= 2'b00;
            r_ce        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_res   <= '0;
            r_rsp_flags <= '0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_req_ready <= w_req_ready;
            r_opa       <= w_opa;
            r_opb       <= w_opb;
            r_cin       <= w_cin;
            r_cmd       <= w_cmd;
            r_mode      <= w_mode;
            r_inp_valid <= w_inp_valid;
            r_ce        <= w_ce;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_res   <= w_rsp_res;
            r_rsp_flags <= w_rsp_flags;
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.opa       = r_opa;
    assign bus.opb       = r_opb;
    assign bus.cin       = r_cin;
    assign bus.cmd       = r_cmd;
    assign bus.mode      = r_mode;
    assign bus.inp_valid = r_inp_valid;
    assign bus.ce        = r_ce;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_res   = r_rsp_res;
    assign bus.rsp_flags = r_rsp_flags;
    assign bus.busy      = (r_state != ST_IDLE);
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU on the bus, directed cases, then
// randomized back-to-back traffic checked in order against a request queue.
`timescale 1ns/1ps
module tb_alu_op_sequencer;
    localparam int WIDTH   = 8;
    localparam int CMD_W   = 4;
    localparam int RES_W   = 16;
    localparam int RES_LAT = 1;
    localparam int MUL_LAT = 2;
    localparam logic [21:0] JUNK = {6'b101010, 16'hDEAD};

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [3:0] cmd;
        logic       mode;
        logic [1:0] iv;
    } req_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    alu_op_sequencer_if #(.WIDTH(WIDTH), .CMD_W(CMD_W), .RES_W(RES_W)) bus ();

    alu_op_sequencer #(
        .WIDTH(WIDTH), .CMD_W(CMD_W), .RES_W(RES_W),
        .RES_LAT(RES_LAT), .MUL_LAT(MUL_LAT), .MUL_CMD0(9), .MUL_CMD1(10)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    // Reference ALU behaviour, returned as {cout,oflow,g,e,l,err,res}.
    function automatic logic [21:0] alu_f(input req_t r);
        logic [15:0] res, a, b;
        logic cout, oflow, g, e, l, err;
        a = 16'(r.a);
        b = 16'(r.b);
        res = '0; cout = 0; oflow = 0; g = 0; e = 0; l = 0; err = 0;
        if (r.iv == 2'b00) err = 1'b1;
        else if (r.mode) begin
            case (r.cmd)
                4'd0:    begin res = a + b; cout = res[8]; end
                4'd1:    begin res = (a - b) & 16'h00FF; oflow = (a < b); end
                4'd2:    begin res = a + b + 16'(r.cin); cout = res[8]; end
                4'd3:    begin res = (a - b - 16'(r.cin)) & 16'h00FF; oflow = (a < b + 16'(r.cin)); end
                4'd8:    begin g = (a > b); e = (a == b); l = (a < b); end
                4'd9:    res = a * b;
                4'd10:   res = (a + 16'd1) * (b + 16'd1);
                default: err = 1'b1;
            endcase
        end else begin
            case (r.cmd)
                4'd0:    res = a & b;
                4'd1:    res = ~(a & b) & 16'h00FF;
                4'd2:    res = a | b;
                4'd3:    res = ~(a | b) & 16'h00FF;
                4'd4:    res = a ^ b;
                4'd5:    res = ~(a ^ b) & 16'h00FF;
                default: err = 1'b1;
            endcase
        end
        return {cout, oflow, g, e, l, err, res};
    endfunction

    function automatic bit is_mul(input req_t r);
        return r.mode && (r.cmd == 4'd9 || r.cmd == 4'd10);
    endfunction

    // ALU on the bus: plain ops answer combinationally, multiply one edge after sampling.
    req_t        alu_in;
    logic [21:0] alu_stage, alu_out;
    logic        alu_stage_v;

    always_comb begin
        alu_in = '{a: bus.opa, b: bus.opb, cin: bus.cin, cmd: bus.cmd, mode: bus.mode, iv: bus.inp_valid};
        alu_out = JUNK;
        if (is_mul(alu_in)) begin
            if (alu_stage_v) alu_out = alu_stage;
        end else if (bus.ce) begin
            alu_out = alu_f(alu_in);
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_stage_v <= 1'b0;
            alu_stage   <= JUNK;
        end else begin
            alu_stage_v <= bus.ce;
            if (bus.ce) alu_stage <= alu_f(alu_in);
        end
    end

    assign bus.res   = alu_out[15:0];
    assign bus.cout  = alu_out[21];
    assign bus.oflow = alu_out[20];
    assign bus.g     = alu_out[19];
    assign bus.e     = alu_out[18];
    assign bus.l     = alu_out[17];
    assign bus.err   = alu_out[16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic req_t rand_req();
        req_t r;
        r.a    = 8'($urandom);
        r.b    = 8'($urandom);
        r.cin  = 1'($urandom);
        r.cmd  = 4'($urandom_range(0, 15));
        r.mode = 1'($urandom);
        r.iv   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
        if ($urandom_range(0, 2) == 0) begin
            r.mode = 1'b1;
            r.cmd  = $urandom_range(0, 1) ? 4'd9 : 4'd10;
        end
        return r;
    endfunction

    task automatic drive_req(input req_t r);
        bus.req_opa  = r.a;
        bus.req_opb  = r.b;
        bus.req_cin  = r.cin;
        bus.req_cmd  = r.cmd;
        bus.req_mode = r.mode;
        bus.req_ivld = r.iv;
    endtask

    function automatic logic [23:0] alu_bus_now();
        return {bus.opa, bus.opb, bus.cmd, bus.mode, bus.cin, bus.inp_valid};
    endfunction

    // One complete transaction; hold_cycles > 0 keeps RSP_READY low that long once valid.
    task automatic run_op(input req_t r, input int hold_cycles, output logic [21:0] got);
        logic [21:0] exp;
        logic [23:0] bus_exp;
        int k, ce_cnt;
        exp     = alu_f(r);
        bus_exp = {r.a, r.b, r.cmd, r.mode, r.cin, r.iv};
        k = 0;
        while (!bus.req_ready && k < 20) begin @(posedge clk); #1; k++; end
        check("req_ready_idle", bus.req_ready, 1);
        drive_req(r);
        bus.req_valid = 1'b1;
        bus.rsp_ready = (hold_cycles == 0);
        @(posedge clk); #1;
        check("alu_bus_latched", alu_bus_now(), bus_exp);
        check("busy_wait", bus.busy, 1);
        drive_req(rand_req());
        ce_cnt = 0;
        k = 1;
        while (!bus.rsp_valid && k < 10) begin
            if (bus.ce) ce_cnt++;
            check("req_ready_wait", bus.req_ready, 0);
            @(posedge clk); #1;
            k++;
        end
        check("rsp_latency", k, is_mul(r) ? 3 : 2);
        check("ce_cycles", ce_cnt, is_mul(r) ? MUL_LAT : RES_LAT);
        check("ce_off_at_rsp", {bus.ce, bus.inp_valid}, 0);
        check("alu_ops_held", {bus.opa, bus.opb, bus.cmd, bus.mode, bus.cin}, bus_exp[23:2]);
        for (int i = 0; i < hold_cycles; i++) begin
            check("bp_rsp_stable", {bus.rsp_valid, bus.rsp_flags, bus.rsp_res}, {1'b1, exp});
            check("bp_idle_bus", {bus.req_ready, bus.ce}, 0);
            @(posedge clk); #1;
        end
        bus.rsp_ready = 1'b1;
        got = {bus.rsp_flags, bus.rsp_res};
        check("rsp_res", bus.rsp_res, exp[15:0]);
        check("rsp_flags", bus.rsp_flags, exp[21:16]);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("after_hs", {bus.rsp_valid, bus.req_ready, bus.busy}, 3'b010);
    endtask

    initial begin
        req_t        r;
        req_t        q[20];
        logic [21:0] got;
        logic [21:0] exp_q[$];
        int          idx, n_rsp;
        bit          acc;

        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        drive_req('0);
        #3;
        check("por_outputs", {bus.req_ready, alu_bus_now(), bus.ce, bus.rsp_valid, bus.busy}, 0);
        check("por_rsp", {bus.rsp_flags, bus.rsp_res}, 0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_rst", bus.req_ready, 1);

        r = '{a: 8'hFF, b: 8'h01, cin: 1'b0, cmd: 4'd0, mode: 1'b1, iv: 2'b11};
        run_op(r, 0, got);
        check("add_res", got[15:0], 16'h0100);
        check("add_cout", got[21], 1);

        r = '{a: 8'h0F, b: 8'h0F, cin: 1'b0, cmd: 4'd9, mode: 1'b1, iv: 2'b11};
        run_op(r, 0, got);
        check("mul_res", got[15:0], 16'h00E1);

        r = '{a: 8'h3C, b: 8'h5A, cin: 1'b1, cmd: 4'd2, mode: 1'b1, iv: 2'b11};
        run_op(r, 5, got);

        r = '{a: 8'h10, b: 8'h10, cin: 1'b0, cmd: 4'd8, mode: 1'b1, iv: 2'b00};
        run_op(r, 0, got);
        check("cmp_err", got[16], 1);

        // Reset in the middle of a multiply.
        r = '{a: 8'h21, b: 8'h03, cin: 1'b0, cmd: 4'd10, mode: 1'b1, iv: 2'b11};
        drive_req(r);
        bus.req_valid = 1'b1;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("pre_rst_busy", {bus.busy, bus.ce}, 2'b11);
        rst_n = 1'b0;
        #1;
        check("rst_outputs", {bus.req_ready, alu_bus_now(), bus.ce, bus.rsp_valid, bus.busy}, 0);
        check("rst_rsp", {bus.rsp_flags, bus.rsp_res}, 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_release_ready", {bus.req_ready, bus.rsp_valid}, 2'b10);
        for (int i = 0; i < 4; i++) begin
            check("no_stale_rsp", {bus.rsp_valid, bus.ce, bus.busy}, 0);
            @(posedge clk); #1;
        end

        for (int i = 0; i < 8; i++) run_op(rand_req(), $urandom_range(0, 2), got);

        // Back-to-back: REQ_VALID held high, junk on REQ_* while not ready.
        for (int i = 0; i < 20; i++) q[i] = rand_req();
        idx = 0;
        n_rsp = 0;
        bus.req_valid = 1'b1;
        bus.rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 400 && n_rsp < 20; cyc++) begin
            if (idx < 20) drive_req(bus.req_ready ? q[idx] : rand_req());
            acc = bus.req_valid && bus.req_ready;
            if (acc) exp_q.push_back(alu_f(q[idx]));
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) check("b2b_spurious_rsp", 1, 0);
                else check("b2b_rsp", {bus.rsp_flags, bus.rsp_res}, exp_q.pop_front());
                n_rsp++;
            end
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx == 20) bus.req_valid = 1'b0;
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
        end
        check("b2b_accepted", idx, 20);
        check("b2b_responses", n_rsp, 20);
        check("b2b_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
